sbs_merge: RTL and testbench

Re-serialises a parallel stereo pixel pair stream into one side-by-side video line, performing the inverse of the half-image splitter. Each input cycle carries one left and one right pixel. The block emits the left half of the line first, then the buffered right half, so the output line is twice as long as the input active period. It sits after the stereo processing stages, in front of the HDMI/file output, so that left/right (or left/disparity) results can be viewed side by side.

---
 rtl/sbs_merge.sv | 253 +++++++++++++++++++++++++
 tb/tb_sbs_merge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbs_merge.sv
// ----------------------------------------------------------------------------
// sbs_merge
//
// Re-serialises a stream of parallel stereo pixel pairs into one side-by-side
// video line. While de_in is high, each cycle delivers one left and one right
// pixel: the left pixel goes straight into the output pipeline, and the right
// pixel is parked in a line buffer. When de_in falls, the buffered right half
// is replayed. The output line is therefore twice as long as the input
// active period, and the left half comes first.
//
// Latency is 2 cycles (stage-1 register, then output register). The line
// buffer read is issued in the same cycle in which a left pixel would be
// forwarded, so RAM read data and the left-pixel path line up at the output
// register.
//
// Parameters
//   HALF_IMG_W : maximum pixel pairs per input line (half the output width)
//   PX_WIDTH   : bits per pixel
//
// Ports
//   clk          in   pixel clock, rising edge
//   rst_n        in   synchronous active-low reset
//   de_in        in   input data enable, one pixel pair per cycle while high
//   h_sync_in    in   horizontal sync (only delayed, never regenerated)
//   v_sync_in    in   vertical sync   (only delayed, never regenerated)
//   pixel_left   in   left-half pixel
//   pixel_right  in   right-half pixel
//   clk_out      out  pass-through of clk
//   de_out       out  output data enable, 2*n cycles per line
//   h_sync_out   out  h_sync_in delayed by 2 cycles
//   v_sync_out   out  v_sync_in delayed by 2 cycles
//   pixel_out    out  side-by-side pixel, 0 while de_out is low
//   err          out  sticky error (overlong line or aborted right half),
//                     cleared only by reset
// ----------------------------------------------------------------------------
module sbs_merge #(
   parameter int HALF_IMG_W = 400,
   parameter int PX_WIDTH   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                de_in,
   input  logic                h_sync_in,
   input  logic                v_sync_in,
   input  logic [PX_WIDTH-1:0] pixel_left,
   input  logic [PX_WIDTH-1:0] pixel_right,
   output logic                clk_out,
   output logic                de_out,
   output logic                h_sync_out,
   output logic                v_sync_out,
   output logic [PX_WIDTH-1:0] pixel_out,
   output logic                err
);

   // Counter width covers 0..HALF_IMG_W; address width covers 0..HALF_IMG_W-1.
   localparam int CW = $clog2(HALF_IMG_W + 1);
   localparam int AW = (HALF_IMG_W > 1) ? $clog2(HALF_IMG_W) : 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(HALF_IMG_W);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LEFT  = 2'd1;
   localparam logic [1:0] ST_RIGHT = 2'd2;

   // ------------------------------------------------------------------------
   // State and pipeline registers
   // ------------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [CW-1:0]       r_wr_cnt;
   logic [CW-1:0]       r_rd_cnt;
   logic [CW-1:0]       r_n;
   logic                r_de_d;
   logic                r_err;

   logic                r_s1_valid;
   logic                r_s1_right;
   logic [PX_WIDTH-1:0] r_s1_left;
   logic                r_s1_hs;
   logic                r_s1_vs;

   logic                r_de_out;
   logic                r_hs_out;
   logic                r_vs_out;
   logic [PX_WIDTH-1:0] r_px_out;

   logic [PX_WIDTH-1:0] r_buf [HALF_IMG_W];
   logic [PX_WIDTH-1:0] r_ram_q;

   // ------------------------------------------------------------------------
   // Next-state signals
   // ------------------------------------------------------------------------
   logic                w_rise;
   logic [1:0]          w_state_nx;
   logic [CW-1:0]       w_wr_cnt_nx;
   logic [CW-1:0]       w_rd_cnt_nx;
   logic [CW-1:0]       w_n_nx;
   logic                w_err_set;
   logic                w_wr_en;
   logic [AW-1:0]       w_wr_addr;
   logic                w_rd_en;
   logic [AW-1:0]       w_rd_addr;
   logic                w_fwd_left;

   assign w_rise = de_in & ~r_de_d;

   // The cycle in which a line starts already carries pair 0, so the start
   // action (write buffer[0], forward left pixel) is taken combinationally in
   // IDLE and on an abort out of RIGHT, not one cycle later in LEFT.
   // Likewise the falling-edge cycle already issues read 0 so the right half
   // follows the left half with no gap.
   always_comb begin
      w_state_nx  = r_state;
      w_wr_cnt_nx = r_wr_cnt;
      w_rd_cnt_nx = r_rd_cnt;
      w_n_nx      = r_n;
      w_err_set   = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_wr_cnt[AW-1:0];
      w_rd_en     = 1'b0;
      w_rd_addr   = r_rd_cnt[AW-1:0];
      w_fwd_left  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_wr_en     = 1'b1;
               w_wr_addr   = '0;
               w_fwd_left  = 1'b1;
               w_wr_cnt_nx = ONE_CNT;
               w_state_nx  = ST_LEFT;
            end
         end

         ST_LEFT: begin
            if (de_in) begin
               if (r_wr_cnt < MAX_CNT) begin
                  w_wr_en     = 1'b1;
                  w_fwd_left  = 1'b1;
                  w_wr_cnt_nx = r_wr_cnt + ONE_CNT;
               end else begin
                  // Buffer full: the pair is dropped and nothing is emitted.
                  w_err_set = 1'b1;
               end
            end else begin
               w_n_nx = r_wr_cnt;
               if (r_wr_cnt == '0) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_rd_en     = 1'b1;
                  w_rd_addr   = '0;
                  w_rd_cnt_nx = ONE_CNT;
                  w_state_nx  = (r_wr_cnt == ONE_CNT) ? ST_IDLE : ST_RIGHT;
               end
            end
         end

         ST_RIGHT: begin
            if (w_rise) begin
               // New line arrived before the right half drained: abandon the
               // rest of it and start the new line in this same cycle.
               w_err_set   = 1'b1;
               w_wr_en     = 1'b1;
               w_wr_addr   = '0;
               w_fwd_left  = 1'b1;
               w_wr_cnt_nx = ONE_CNT;
               w_state_nx  = ST_LEFT;
            end else begin
               w_rd_en     = 1'b1;
               w_rd_cnt_nx = r_rd_cnt + ONE_CNT;
               if (r_rd_cnt + ONE_CNT == r_n) begin
                  w_state_nx = ST_IDLE;
               end
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control state, stage-1 and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_n        <= '0;
         // Held high so that a de_in already high at reset release is not
         // taken as a line start; a clean low-to-high edge is required.
         r_de_d     <= 1'b1;
         r_err      <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_right <= 1'b0;
         r_s1_left  <= '0;
         r_de_out   <= 1'b0;
         r_hs_out   <= 1'b0;
         r_vs_out   <= 1'b0;
         r_px_out   <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_wr_cnt   <= w_wr_cnt_nx;
         r_rd_cnt   <= w_rd_cnt_nx;
         r_n        <= w_n_nx;
         r_de_d     <= de_in;
         r_err      <= r_err | w_err_set;
         r_s1_valid <= w_fwd_left | w_rd_en;
         r_s1_right <= w_rd_en;
         r_s1_left  <= pixel_left;
         r_de_out   <= r_s1_valid;
         r_hs_out   <= r_s1_hs;
         r_vs_out   <= r_s1_vs;
         if (r_s1_valid) begin
            r_px_out <= r_s1_right ? r_ram_q : r_s1_left;
         end else begin
            r_px_out <= '0;
         end
      end
   end

   // The first sync stage is deliberately not reset: the syncs stay a pure
   // 2-cycle delay of the inputs straight after reset release, while the
   // reset output stage still forces them low during reset.
   always_ff @(posedge clk) begin
      r_s1_hs <= h_sync_in;
      r_s1_vs <= v_sync_in;
   end

   // ------------------------------------------------------------------------
   // Line buffer: one write port, one registered read port, no reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_buf[w_wr_addr] <= pixel_right;
      end
      if (w_rd_en) begin
         r_ram_q <= r_buf[w_rd_addr];
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign clk_out    = clk;
   assign de_out     = r_de_out;
   assign h_sync_out = r_hs_out;
   assign v_sync_out = r_vs_out;
   assign pixel_out  = r_px_out;
   assign err        = r_err;

endmodule

// File: tb/tb_sbs_merge.sv
// ----------------------------------------------------------------------------
// tb_sbs_merge
//
// Line plans (start offset, pair count, pixel values) are turned into a list
// of (cycle, pixel) output events from the line-level rules of the block:
// left pixel k at start+2+k, right pixel k at start+2+m+k unless the next
// line starts first, at most HALF_IMG_W pixels per half, and nothing after a
// reset. A monitor on the falling clock edge pops and compares those events
// and also checks idle outputs, err, and the 2-cycle sync delay.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sbs_merge;

   localparam int W   = 4;
   localparam int BIG = 32'h3fff_ffff;
   localparam int HS  = 4096;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       de_in = 1'b0;
   logic       h_sync_in = 1'b0;
   logic       v_sync_in = 1'b0;
   logic [7:0] pixel_left = '0;
   logic [7:0] pixel_right = '0;
   logic       clk_out;
   logic       de_out;
   logic       h_sync_out;
   logic       v_sync_out;
   logic [7:0] pixel_out;
   logic       err;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int err_from = BIG;

   bit rst_hist [HS];
   bit hs_hist  [HS];
   bit vs_hist  [HS];

   typedef struct {
      int         cyc;
      logic [7:0] px;
   } exp_t;
   exp_t q[$];

   int         nl;
   int         ln_off [8];
   int         ln_m   [8];
   logic [7:0] ln_l   [8][8];
   logic [7:0] ln_r   [8][8];

   sbs_merge #(
      .HALF_IMG_W (W),
      .PX_WIDTH   (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .de_in       (de_in),
      .h_sync_in   (h_sync_in),
      .v_sync_in   (v_sync_in),
      .pixel_left  (pixel_left),
      .pixel_right (pixel_right),
      .clk_out     (clk_out),
      .de_out      (de_out),
      .h_sync_out  (h_sync_out),
      .v_sync_out  (v_sync_out),
      .pixel_out   (pixel_out),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic push_exp(input int t, input logic [7:0] px, input int cut);
      exp_t e;
      if (t <= cut) begin
         e.cyc = t;
         e.px  = px;
         q.push_back(e);
      end
   endtask

   // Random sync patterns, independent of the pixel stimulus.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         h_sync_in = 1'($urandom);
         v_sync_in = 1'($urandom);
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin : mon
      int c;
      c = cyc;
      rst_hist[c % HS] = rst_n;
      hs_hist[c % HS]  = h_sync_in;
      vs_hist[c % HS]  = v_sync_in;
      if (c >= 2) begin
         chk("clk_out", clk_out, clk);
         if (!rst_hist[(c - 1) % HS]) begin
            chk("rst_err", err, 0);
            chk("rst_hsync", h_sync_out, 0);
            chk("rst_vsync", v_sync_out, 0);
         end else begin
            chk("hsync_delay", h_sync_out, hs_hist[(c - 2) % HS]);
            chk("vsync_delay", v_sync_out, vs_hist[(c - 2) % HS]);
            if (rst_hist[c % HS]) chk("err", err, (c >= err_from));
         end
         while (q.size() > 0 && q[0].cyc < c) begin
            chk("stale_exp", q[0].cyc, c);
            q.delete(0);
         end
         if (q.size() > 0 && q[0].cyc == c) begin
            chk("de_out", de_out, 1);
            chk("pixel", pixel_out, q[0].px);
            q.delete(0);
         end else begin
            chk("de_out_idle", de_out, 0);
            chk("pixel_idle", pixel_out, 0);
         end
      end
   end

   // Build expected events for the current plan and drive it. cut_off >= 0
   // asserts reset at that cycle offset and returns with de_in held high.
   task automatic run_plan(input int cut_off);
      int t0, s, s_nx, n, rc, last, c, cut;
      t0  = cyc + 1;
      cut = (cut_off < 0) ? BIG : t0 + cut_off;
      for (int i = 0; i < nl; i++) begin
         s    = t0 + ln_off[i];
         s_nx = (i + 1 < nl) ? t0 + ln_off[i + 1] : BIG;
         n    = (ln_m[i] > W) ? W : ln_m[i];
         if (ln_m[i] > W && s + W < cut && s + W + 1 < err_from) err_from = s + W + 1;
         for (int k = 0; k < n; k++) push_exp(s + 2 + k, ln_l[i][k], cut);
         for (int k = 0; k < n; k++) begin
            rc = s + ln_m[i] + k;
            if (rc < s_nx) begin
               push_exp(rc + 2, ln_r[i][k], cut);
            end else begin
               if (s_nx < cut && s_nx + 1 < err_from) err_from = s_nx + 1;
               break;
            end
         end
      end
      last = t0 + ln_off[nl - 1] + 2 * ln_m[nl - 1] + 4;
      forever begin
         @(posedge clk);
         #1;
         c = cyc;
         if (c > last) break;
         pixel_left  = 8'($urandom);
         pixel_right = 8'($urandom);
         if (c == cut) begin
            rst_n    = 1'b0;
            err_from = BIG;
            de_in    = 1'b1;
            return;
         end
         de_in = 1'b0;
         for (int i = 0; i < nl; i++) begin
            if (c >= t0 + ln_off[i] && c < t0 + ln_off[i] + ln_m[i]) begin
               de_in       = 1'b1;
               pixel_left  = ln_l[i][c - t0 - ln_off[i]];
               pixel_right = ln_r[i][c - t0 - ln_off[i]];
            end
         end
      end
      de_in = 1'b0;
   endtask

   task automatic rand_plan(input int lines, input bit allow_abort);
      int off, m;
      off = 0;
      nl  = lines;
      for (int i = 0; i < lines; i++) begin
         m         = int'($urandom_range(1, W));
         ln_m[i]   = m;
         ln_off[i] = off;
         for (int k = 0; k < 8; k++) begin
            ln_l[i][k] = 8'($urandom);
            ln_r[i][k] = 8'($urandom);
         end
         if (allow_abort) off = off + m + 1 + int'($urandom_range(0, m + 1));
         else             off = off + 2 * m + int'($urandom_range(0, 3));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      err_from = BIG;
      de_in    = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   task automatic set_line(input int i, input int off, input int m,
                           input int lbase, input int rbase);
      ln_off[i] = off;
      ln_m[i]   = m;
      for (int k = 0; k < 8; k++) begin
         ln_l[i][k] = 8'(lbase + k);
         ln_r[i][k] = 8'(rbase + k);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic order
      nl = 1; set_line(0, 0, 4, 10, 20); run_plan(-1);
      // Back-to-back lines, starts 8 cycles apart
      rand_plan(2, 1'b0); ln_off[0] = 0; ln_m[0] = 4; ln_off[1] = 8; ln_m[1] = 4;
      run_plan(-1);
      // Short line
      nl = 1; set_line(0, 0, 2, 1, 5); run_plan(-1);
      // Random legal lines, no error expected
      rand_plan(6, 1'b0); run_plan(-1);
      // Overlong line: 6 pairs into a 4-wide buffer
      nl = 1; set_line(0, 0, 6, 1, 11); run_plan(-1);
      do_reset();
      // Early next line, 5 cycles after a 4-pair line started
      nl = 2; set_line(0, 0, 4, 10, 20); set_line(1, 5, 4, 30, 40); run_plan(-1);
      do_reset();
      // Random lines with possible aborts
      rand_plan(6, 1'b1); run_plan(-1);
      // Reset during RIGHT, de_in held high across reset release
      nl = 1; set_line(0, 0, 4, 50, 60); run_plan(6);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         pixel_left  = 8'($urandom);
         pixel_right = 8'($urandom);
      end
      de_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Full line after the reset
      nl = 1; set_line(0, 0, 4, 70, 80); run_plan(-1);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      chk("drain_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
